// File: rtl/tile_texture_gen.sv
// Tile texture generator: tile-local ROM address, latency-matched timing, colour select; optional TILE_ANIM_EN animation.
// Latency ROM_LAT+1 cycles (texture_addr combinational); no backpressure, one pixel accepted per clk.
module tile_texture_gen #(
  parameter int          TILE_LOG2 = 5,
  parameter int          TEX_BITS  = 3,
  parameter int          ANIM_LOG2 = 1,
  parameter int          ANIM_DIV  = 8,
  parameter int          ROM_LAT   = 1,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  localparam int         AW        = TEX_BITS + ANIM_LOG2 + 2 * TILE_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                hblank,
  input  logic                vblank,
  input  logic [10:0]         hcount,
  input  logic [10:0]         vcount,
  input  logic [11:0]         rgb,
  input  logic [TEX_BITS-1:0] texture_number,
  input  logic                inversion,
  input  logic                transparent_en,
  input  logic                anim_hold,
  output logic [AW-1:0]       texture_addr,
  input  logic [11:0]         texture_rgb,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                hblank_out,
  output logic                vblank_out,
  output logic [10:0]         hcount_out,
  output logic [10:0]         vcount_out,
  output logic [11:0]         rgb_out
);

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [10:0] hc;
    logic [10:0] vc;
  } tim_t;

  typedef struct packed {
    tim_t        tim;
    logic [11:0] rgb;
    logic        inv;
    logic        tr;
  } pix_t;

  pix_t                 pix_in;
  pix_t                 pix_al;
  tim_t                 tim_q;
  logic [11:0]          rgb_out_q;
  logic [11:0]          rgb_d;
  logic [ANIM_LOG2-1:0] anim_frame;

  always_comb begin
    pix_in        = '0;
    pix_in.tim.hs = hsync;
    pix_in.tim.vs = vsync;
    pix_in.tim.hb = hblank;
    pix_in.tim.vb = vblank;
    pix_in.tim.hc = hcount;
    pix_in.tim.vc = vcount;
    pix_in.rgb    = rgb;
    pix_in.inv    = inversion;
    pix_in.tr     = transparent_en;
  end

  assign texture_addr = {texture_number, anim_frame,
                         vcount[TILE_LOG2-1:0], hcount[TILE_LOG2-1:0]};

  // Pixel attributes ride alongside the ROM access so they meet texture_rgb.
  generate
    if (ROM_LAT == 0) begin : g_nodl
      assign pix_al = pix_in;
    end else begin : g_dl
      pix_t dl_q [ROM_LAT];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < ROM_LAT; i++) dl_q[i] <= '0;
        end else begin
          dl_q[0] <= pix_in;
          for (int i = 1; i < ROM_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign pix_al = dl_q[ROM_LAT-1];
    end
  endgenerate

  always_comb begin
    rgb_d = texture_rgb;
    if (pix_al.tim.hb || pix_al.tim.vb) begin
      rgb_d = 12'h000;
    end else if (pix_al.tr && (texture_rgb == KEY_COLOR)) begin
      rgb_d = pix_al.rgb;
    end else if (pix_al.inv) begin
      rgb_d = ~texture_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tim_q     <= '0;
      rgb_out_q <= '0;
    end else begin
      tim_q     <= pix_al.tim;
      rgb_out_q <= rgb_d;
    end
  end

  assign hsync_out  = tim_q.hs;
  assign vsync_out  = tim_q.vs;
  assign hblank_out = tim_q.hb;
  assign vblank_out = tim_q.vb;
  assign hcount_out = tim_q.hc;
  assign vcount_out = tim_q.vc;
  assign rgb_out    = rgb_out_q;

`ifdef TILE_ANIM_EN
  logic                 vs_q;
  logic                 arm_q;
  logic                 vs_rise;
  logic [7:0]           frame_div_q;
  logic [7:0]           frame_div_d;
  logic [ANIM_LOG2-1:0] anim_frame_q;
  logic [ANIM_LOG2-1:0] anim_frame_d;

  // arm_q masks the first cycle after reset so a vsync already high is not an edge.
  assign vs_rise = vsync & ~vs_q & arm_q & ~anim_hold;

  always_comb begin
    frame_div_d  = frame_div_q;
    anim_frame_d = anim_frame_q;
    if (vs_rise) begin
      if (frame_div_q == 8'(ANIM_DIV - 1)) begin
        frame_div_d  = 8'd0;
        anim_frame_d = anim_frame_q + ANIM_LOG2'(1);
      end else begin
        frame_div_d  = frame_div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q         <= 1'b0;
      arm_q        <= 1'b0;
      frame_div_q  <= '0;
      anim_frame_q <= '0;
    end else begin
      vs_q         <= vsync;
      arm_q        <= 1'b1;
      frame_div_q  <= frame_div_d;
      anim_frame_q <= anim_frame_d;
    end
  end

  assign anim_frame = anim_frame_q;
`else
  logic unused_anim_hold;
  assign unused_anim_hold = anim_hold;
  assign anim_frame       = '0;
`endif

endmodule

// File: tb/tb_tile_texture_gen.sv
// Bench for tile_texture_gen: ROM_LAT=1 and ROM_LAT=3 instances share stimulus, ROM image and a frame-count model.
module tb_tile_texture_gen;

  localparam int TB_DIV = 2;
`ifdef TILE_ANIM_EN
  localparam bit ANIM_ON = 1'b1;
`else
  localparam bit ANIM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, hsync, vsync, hblank, vblank, inversion, transparent_en, anim_hold;
  logic [10:0] hcount, vcount;
  logic [11:0] rgb;
  logic [2:0]  texture_number;

  logic [13:0] addr1, addr3;
  logic [11:0] trgb1, trgb3, rgbo1, rgbo3;
  logic        hso1, vso1, hbo1, vbo1, hso3, vso3, hbo3, vbo3;
  logic [10:0] hco1, vco1, hco3, vco3;

  logic [11:0] mem [0:16383];
  logic [13:0] a1_1, a3_1, a3_2, a3_3;

  always @(posedge clk) begin
    a1_1 <= addr1;
    a3_1 <= addr3;
    a3_2 <= a3_1;
    a3_3 <= a3_2;
  end
  assign trgb1 = mem[a1_1];
  assign trgb3 = mem[a3_3];

  tile_texture_gen #(.ANIM_DIV(TB_DIV), .ROM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .hcount(hcount), .vcount(vcount), .rgb(rgb), .texture_number(texture_number),
    .inversion(inversion), .transparent_en(transparent_en), .anim_hold(anim_hold),
    .texture_addr(addr1), .texture_rgb(trgb1),
    .hsync_out(hso1), .vsync_out(vso1), .hblank_out(hbo1), .vblank_out(vbo1),
    .hcount_out(hco1), .vcount_out(vco1), .rgb_out(rgbo1));

  tile_texture_gen #(.ANIM_DIV(TB_DIV), .ROM_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .hcount(hcount), .vcount(vcount), .rgb(rgb), .texture_number(texture_number),
    .inversion(inversion), .transparent_en(transparent_en), .anim_hold(anim_hold),
    .texture_addr(addr3), .texture_rgb(trgb3),
    .hsync_out(hso3), .vsync_out(vso3), .hblank_out(hbo3), .vblank_out(vbo3),
    .hcount_out(hco3), .vcount_out(vco3), .rgb_out(rgbo3));

  typedef struct {
    logic        hs, vs, hb, vb, inv, tr;
    logic [10:0] hc, vc;
    logic [11:0] rgb;
    logic [13:0] addr;
    bit          rst;
  } rec_t;

  rec_t hist[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   n_edges = 0;
  int   good = 0;
  bit   armed = 0;
  bit   pvs = 0;
  bit   started = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Animation frame is the number of counted vsync edges, divided down and wrapped.
  function automatic logic frame_now();
    if (ANIM_ON) return 1'((n_edges / TB_DIV) % 2);
    return 1'b0;
  endfunction

  function automatic logic [13:0] maddr(input logic [2:0] tex, input logic [10:0] vc,
                                        input logic [10:0] hc);
    return {tex, frame_now(), vc[4:0], hc[4:0]};
  endfunction

  function automatic logic [37:0] exp_out(input rec_t r);
    logic [11:0] t, c;
    t = mem[r.addr];
    if (r.hb || r.vb)                c = 12'h000;
    else if (r.tr && t == 12'hF0F)   c = r.rgb;
    else if (r.inv)                  c = ~t;
    else                             c = t;
    return {r.hs, r.vs, r.hb, r.vb, r.hc, r.vc, c};
  endfunction

  task automatic step();
    rec_t r;
    @(negedge clk);
    if (started) begin
      chk("addr1", addr1, maddr(texture_number, vcount, hcount));
      chk("addr3", addr3, maddr(texture_number, vcount, hcount));
    end
    @(posedge clk);
    r.hs = hsync; r.vs = vsync; r.hb = hblank; r.vb = vblank;
    r.inv = inversion; r.tr = transparent_en;
    r.hc = hcount; r.vc = vcount; r.rgb = rgb;
    r.addr = maddr(texture_number, vcount, hcount);
    r.rst = rst_n;
    hist.push_back(r);
    if (hist.size() > 5) void'(hist.pop_front());
    started = 1;
    if (!rst_n) begin
      n_edges = 0; armed = 0; pvs = 0; good = 0;
    end else begin
      if (armed && vsync && !pvs && !anim_hold) n_edges++;
      pvs = vsync; armed = 1; good++;
    end
    #1;
    if (!r.rst) begin
      chk("rst_out1", {hso1, vso1, hbo1, vbo1, hco1, vco1, rgbo1}, 0);
      chk("rst_out3", {hso3, vso3, hbo3, vbo3, hco3, vco3, rgbo3}, 0);
    end else begin
      if (good >= 2)
        chk("out1", {hso1, vso1, hbo1, vbo1, hco1, vco1, rgbo1}, exp_out(hist[hist.size()-2]));
      if (good >= 4)
        chk("out3", {hso3, vso3, hbo3, vbo3, hco3, vco3, rgbo3}, exp_out(hist[hist.size()-4]));
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1; steps(2);
    vsync = 1'b0; steps(3);
  endtask

  task automatic set_pixel(input logic [2:0] tex, input logic [10:0] vc, input logic [10:0] hc);
    texture_number = tex; vcount = vc; hcount = hc;
  endtask

  initial begin : main
    logic [4:0] hs_v1, hs_v3;
    logic [3:0] seq;

    for (int i = 0; i < 16384; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 12'hF0F : 12'($urandom);
    mem[{3'd3, 1'b0, 5'd6, 5'd5}] = 12'h5A7;
    mem[{3'd5, 1'b0, 5'd9, 5'd5}] = 12'h123;
    mem[{3'd6, 1'b0, 5'd2, 5'd3}] = 12'hF0F;

    rst_n = 0; hsync = 0; vsync = 0; hblank = 0; vblank = 0; inversion = 0;
    transparent_en = 0; anim_hold = 0; hcount = 0; vcount = 0; rgb = 0; texture_number = 0;

    // Reset with busy inputs
    for (int i = 0; i < 4; i++) begin
      hsync = 1'($urandom); hblank = 1'($urandom); inversion = 1'($urandom);
      hcount = 11'($urandom); vcount = 11'($urandom); rgb = 12'($urandom);
      texture_number = 3'($urandom);
      step();
    end
    chk("reset_rgb1", rgbo1, 12'h000);
    chk("reset_hc3", hco3, 11'd0);

    rst_n = 1; hsync = 0; hblank = 0; inversion = 0; rgb = 12'h000;
    set_pixel(3'd3, 11'd70, 11'd37);
    steps(5);
    chk("addr_197", addr1[9:0], 10'd197);
    chk("texel1", rgbo1, 12'h5A7);
    chk("texel3", rgbo3, 12'h5A7);

    set_pixel(3'd5, 11'd9, 11'd5); inversion = 1;
    steps(5);
    chk("invert1", rgbo1, 12'hEDC);
    chk("invert3", rgbo3, 12'hEDC);

    set_pixel(3'd6, 11'd2, 11'd3); transparent_en = 1; rgb = 12'h0A0;
    steps(5);
    chk("key1", rgbo1, 12'h0A0);
    chk("key3", rgbo3, 12'h0A0);

    hblank = 1;
    steps(5);
    chk("blank1", rgbo1, 12'h000);
    chk("blank3", rgbo3, 12'h000);
    hblank = 0; transparent_en = 0; inversion = 0;

    // Single-cycle hsync pulse with a ramping hcount
    hsync = 1; hcount = 11'd100;
    step();
    hsync = 0;
    for (int i = 0; i < 5; i++) begin
      hcount = hcount + 11'd1;
      step();
      hs_v1[i] = hso1;
      hs_v3[i] = hso3;
      if (i >= 2) chk("hc_offset3", hco3, hcount - 11'd3);
    end
    chk("hs_lat1", hs_v1, 5'b00001);
    chk("hs_lat3", hs_v3, 5'b00100);

    // Animation: vsync high through reset release must not count
    vsync = 1; rst_n = 0; steps(2);
    rst_n = 1; steps(3);
    vsync = 0; steps(3);
    seq = ANIM_ON ? 4'b0110 : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      vs_pulse();
      chk("anim_seq", addr1[10], seq[i]);
    end
    vs_pulse();
    chk("anim_pre_hold", addr3[10], 1'b0);
    anim_hold = 1;
    for (int i = 0; i < 3; i++) begin
      vs_pulse();
      chk("anim_hold", addr1[10], 1'b0);
    end
    anim_hold = 0;
    vs_pulse();
    chk("anim_resume", addr1[10], ANIM_ON);

    // Randomised traffic including occasional resets and holds
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      hsync = 1'($urandom);
      if ($urandom_range(0, 5) == 0) vsync = ~vsync;
      hblank = ($urandom_range(0, 3) == 0);
      vblank = ($urandom_range(0, 3) == 0);
      inversion = 1'($urandom);
      transparent_en = 1'($urandom);
      anim_hold = ($urandom_range(0, 3) == 0);
      hcount = 11'($urandom); vcount = 11'($urandom);
      rgb = 12'($urandom); texture_number = 3'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
